// File: rtl/xs3_stream_decoder.sv
// Excess-3 digit stream receiver: decodes each digit to BCD, accumulates the
// number in binary and presents the result on a valid/ready port.
module xs3_stream_decoder #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned OUT_W  = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_code,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_bin,
    output logic [4*DIGITS-1:0]           out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]   out_ndig,
    output logic                          out_err
);

    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    logic               w_accept;
    logic               w_code_ok;
    logic               w_room;
    logic [3:0]         w_digit;
    logic [OUT_W-1:0]   w_acc_next;

    // Handshake depends only on state and reset, never on the output side
    assign in_ready   = (r_state == ST_ACC) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_code_ok  = (in_code >= 4'd3) && (in_code <= 4'd12);
    assign w_room     = r_count < CNT_W'(DIGITS);
    assign w_digit    = in_code - 4'd3;
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + OUT_W'(w_digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_bcd   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        // Invalid codes and digits beyond capacity are dropped but flagged
                        if (w_code_ok && w_room) begin
                            r_acc   <= w_acc_next;
                            r_bcd   <= {r_bcd[BCD_W-5:0], w_digit};
                            r_count <= r_count + CNT_W'(1);
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (in_last) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_ACC;
                        r_acc   <= '0;
                        r_bcd   <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign out_valid = (r_state == ST_HOLD);
    assign out_bin   = r_acc;
    assign out_bcd   = r_bcd;
    assign out_ndig  = r_count;
    assign out_err   = r_err;

endmodule

// File: tb/tb_xs3_stream_decoder.sv
// Cycle-table bench for xs3_stream_decoder: each row gives this cycle's inputs
// and the outputs expected before the next rising edge.
module tb_xs3_stream_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_bin;
    logic [15:0] out_bcd;
    logic [2:0]  out_ndig;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    xs3_stream_decoder #(.DIGITS(4), .OUT_W(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_bcd   (out_bcd),
        .out_ndig  (out_ndig),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  code;
        logic        last;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic        chk_data;
        logic [13:0] exp_bin;
        logic [15:0] exp_bcd;
        logic [2:0]  exp_nd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic iv, logic [3:0] code, logic last, logic ordy,
                                logic ir, logic ov, logic cd, logic [13:0] bin,
                                logic [15:0] bcd, logic [2:0] nd, logic err);
        vec_t v;
        v.rst = r; v.iv = iv; v.code = code; v.last = last; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.chk_data = cd;
        v.exp_bin = bin; v.exp_bcd = bcd; v.exp_nd = nd; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [13:0] bin, input logic [15:0] bcd,
                            input logic [2:0] nd, input logic err);
        chk({tag, " out_bin"},  32'(out_bin),  32'(bin));
        chk({tag, " out_bcd"},  32'(out_bcd),  32'(bcd));
        chk({tag, " out_ndig"}, 32'(out_ndig), 32'(nd));
        chk({tag, " out_err"},  32'(out_err),  32'(err));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = 4'h0; in_last = 1'b0; out_ready = 1'b0;

        // reset held two cycles with a digit offered, then idle
        tbl.push_back(mk(1,1,4'h4,0,0, 0,0,1, 0,16'h0000,0,0));
        tbl.push_back(mk(1,1,4'h4,0,0, 0,0,1, 0,16'h0000,0,0));
        tbl.push_back(mk(0,0,4'h0,0,0, 1,0,1, 0,16'h0000,0,0));
        // normal frame 1538 with out_ready held high
        tbl.push_back(mk(0,1,4'h4,0,1, 1,0,1, 0,16'h0000,0,0));
        tbl.push_back(mk(0,1,4'h8,0,1, 1,0,1, 1,16'h0001,1,0));
        tbl.push_back(mk(0,1,4'h6,0,1, 1,0,1, 15,16'h0015,2,0));
        tbl.push_back(mk(0,1,4'hB,1,1, 1,0,1, 153,16'h0153,3,0));
        tbl.push_back(mk(0,0,4'h0,0,1, 0,1,1, 1538,16'h1538,4,0));
        tbl.push_back(mk(0,0,4'h0,0,1, 1,0,1, 0,16'h0000,0,0));
        // invalid code dropped
        tbl.push_back(mk(0,1,4'h4,0,0, 1,0,1, 0,16'h0000,0,0));
        tbl.push_back(mk(0,1,4'hF,0,0, 1,0,1, 1,16'h0001,1,0));
        tbl.push_back(mk(0,1,4'h5,1,0, 1,0,1, 1,16'h0001,1,1));
        tbl.push_back(mk(0,0,4'h0,0,1, 0,1,1, 12,16'h0012,2,1));
        tbl.push_back(mk(0,0,4'h0,0,0, 1,0,1, 0,16'h0000,0,0));
        // overflow: five nines
        tbl.push_back(mk(0,1,4'hC,0,0, 1,0,1, 0,16'h0000,0,0));
        tbl.push_back(mk(0,1,4'hC,0,0, 1,0,1, 9,16'h0009,1,0));
        tbl.push_back(mk(0,1,4'hC,0,0, 1,0,1, 99,16'h0099,2,0));
        tbl.push_back(mk(0,1,4'hC,0,0, 1,0,1, 999,16'h0999,3,0));
        tbl.push_back(mk(0,1,4'hC,1,0, 1,0,1, 9999,16'h9999,4,0));
        tbl.push_back(mk(0,0,4'h0,0,1, 0,1,1, 9999,16'h9999,4,1));
        tbl.push_back(mk(0,0,4'h0,0,0, 1,0,1, 0,16'h0000,0,0));
        // backpressure: five held cycles with a digit offered, then release
        tbl.push_back(mk(0,1,4'h3,1,0, 1,0,1, 0,16'h0000,0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0,1,4'h7,0,0, 0,1,1, 0,16'h0000,1,0));
        tbl.push_back(mk(0,1,4'h7,0,1, 0,1,1, 0,16'h0000,1,0));
        tbl.push_back(mk(0,1,4'h7,1,1, 1,0,1, 0,16'h0000,0,0));
        tbl.push_back(mk(0,0,4'h0,0,1, 0,1,1, 4,16'h0004,1,0));
        tbl.push_back(mk(0,0,4'h0,0,0, 1,0,1, 0,16'h0000,0,0));
        // reset mid-frame discards the partial number
        tbl.push_back(mk(0,1,4'h5,0,0, 1,0,1, 0,16'h0000,0,0));
        tbl.push_back(mk(0,1,4'h6,0,0, 1,0,1, 2,16'h0002,1,0));
        tbl.push_back(mk(1,0,4'h0,0,0, 0,0,1, 23,16'h0023,2,0));
        tbl.push_back(mk(0,1,4'hA,1,0, 1,0,1, 0,16'h0000,0,0));
        tbl.push_back(mk(0,0,4'h0,0,1, 0,1,1, 7,16'h0007,1,0));
        tbl.push_back(mk(0,0,4'h0,0,0, 1,0,1, 0,16'h0000,0,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            in_code   = tbl[i].code;
            in_last   = tbl[i].last;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d in_ready", i),  32'(in_ready),  32'(tbl[i].exp_ir));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].chk_data)
                chk_data($sformatf("row%0d", i), tbl[i].exp_bin, tbl[i].exp_bcd,
                         tbl[i].exp_nd, tbl[i].exp_err);
            @(negedge clk);
        end

        // error-only frame: a single invalid code marked last
        begin
            bit seen = 1'b0;
            rst = 1'b0; in_valid = 1'b1; in_code = 4'h0; in_last = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                #1;
                if (out_valid) seen = 1'b1;
                else @(negedge clk);
            end
            chk("errframe out_valid seen", 32'(seen), 32'd1);
            chk_data("errframe", 14'd0, 16'h0000, 3'd0, 1'b1);
            out_ready = 1'b1;
            @(negedge clk);
            #1;
            chk("errframe drained out_valid", 32'(out_valid), 32'd0);
            chk("errframe drained in_ready",  32'(in_ready),  32'd1);
            chk_data("errframe drained", 14'd0, 16'h0000, 3'd0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xs3_stream_decoder.md
# xs3_stream_decoder

Receives a stream of excess-3 coded decimal digits, most significant digit first, over a valid/ready handshake. Decodes each digit to BCD and accumulates a multi-digit number into binary. Presents the finished number, its BCD digits, the digit count and an error flag on a valid/ready output port. Sits on the receive side of the excess-3 digit link, undoing the binary-to-excess-3 encoding applied by the transmitting side.

## Interface
- DIGITS, 4, maximum digits per number
- OUT_W, 14, binary result width; must satisfy 2^OUT_W > 10^DIGITS - 1
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_code/in_last valid
- in_ready  output  1  decoder accepts a digit this cycle
- in_code  input  4  excess-3 digit (valid codes 4'h3..4'hC)
- in_last  input  1  marks the final digit of a number
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_bin  output  OUT_W  binary value of accepted digits
- out_bcd  output  4*DIGITS  accepted digits as BCD, least significant digit in [3:0], unused upper digits 0
- out_ndig  output  $clog2(DIGITS+1)  number of digits accumulated
- out_err  output  1  frame contained an invalid code or more than DIGITS digits

## Operation
- Two states: ACC (collecting) and HOLD (result presented). Reset state is ACC.
- Reset values: out_valid=0, out_bin=0, out_bcd=0, out_ndig=0, out_err=0. in_ready=0 while rst=1.
- ACC: in_ready=1, out_valid=0. A digit is accepted on in_valid & in_ready.
- Decoding: d = in_code - 3 (4-bit). The code is valid iff 3 <= in_code <= 12.
- If the code is valid and count < DIGITS:
  - acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d in OUT_W bits.
  - bcd <= {bcd[4*DIGITS-5:0], d}.
  - count += 1.
- If the code is invalid: err <= 1. acc, bcd and count are unchanged (digit dropped).
- If the code is valid and count == DIGITS: err <= 1. The digit is dropped (overflow).
- Accepted digit with in_last=1: processed as above in the same cycle, then the state goes to HOLD.
- HOLD: in_ready=0 and out_valid=1. out_* show acc/bcd/count/err and are held stable. in_valid is ignored.
- HOLD with out_ready=1: the result is consumed. acc, bcd, count and err clear to 0, and the state returns to ACC.
- Error-only frame (no valid digits): out_bin=0, out_ndig=0, out_err=1.
- rst=1 in any state: the partial frame or held result is discarded, and all registers return to their reset values on the next edge.

## Timing
- One digit per cycle sustained in ACC.
- Result latency: out_valid rises on the edge that accepts the in_last digit. Output data is registered and valid in the same cycle out_valid is high.
- Output handshake completes on a rising edge with out_valid & out_ready. in_ready=1 in the following cycle, which gives a one-cycle bubble between frames.
- out_ready may be held high continuously. The result is then visible for exactly one cycle.
- in_ready depends only on state and rst, never combinationally on out_ready or in_valid.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0. After release, in_ready=1 on the next cycle and no digit is accepted during reset.
- Normal frame: codes 4'h4, 4'h8, 4'h6, 4'hB on consecutive cycles, in_last on the 4th, out_ready=1 -> one cycle later out_valid=1, out_bin=1538, out_bcd=16'h1538, out_ndig=4, out_err=0. in_ready=1 on the following cycle.
- Invalid code: 4'h4, 4'hF, 4'h5 (last) -> out_bin=12, out_bcd=16'h0012, out_ndig=2, out_err=1.
- Overflow: five codes 4'hC, last on the 5th -> out_bin=9999, out_bcd=16'h9999, out_ndig=4, out_err=1.
- Backpressure: after the frame 4'h3 (last), hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_valid stays 1, out_bin=0, out_ndig=1, outputs stable, in_ready=0, no digit accepted. Then set out_ready=1 -> next cycle out_valid=0, in_ready=1, and the next frame 4'h7 (last) gives out_bin=4.
- Reset mid-frame: accept 4'h5, 4'h6, assert rst for 1 cycle, then send 4'hA (last) -> out_bin=7, out_bcd=16'h0007, out_ndig=1, out_err=0.
